routex_tx_arb: RTL and testbench
================================

Name: routex_tx_arb

Overview:
- Output-side packet arbiter directly downstream of the routex receive buffers.
- Takes NUMPORTS flit streams, 8 lanes x 64 bit each (one stream per receive buffer output), and merges them onto one output flit stream.
- Arbitration is round-robin at packet granularity; a granted packet is never interleaved with another.
- Packet length comes from the header flit. No last-flit signal exists.

Parameters:
- NUMPORTS, 4, number of input streams (2..8).
- PW, 2, width of the source-index field; must be at least clog2(NUMPORTS).

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  reset, asynchronous assert, active-low (0 = reset).
- D  in  NUMPORTS*8*64  input flits; port i occupies bits [i*512 +: 512]; lane k of port i is [i*512+k*64 +: 64].
- D_VALID  in  NUMPORTS  per-port flit valid.
- D_BP  out  NUMPORTS  per-port backpressure. A flit transfers on port i when D_VALID[i] & ~D_BP[i].
- Q  out  8*64  output flit, registered.
- Q_VALID  out  1  output flit valid.
- Q_SRC  out  PW  index of the source port of the current Q flit.
- Q_HEAD  out  1  marks Q as a header flit.
- Q_BP  in  1  downstream backpressure. A flit leaves when Q_VALID & ~Q_BP.

Behaviour:
Header format:
- The first flit of every packet is the header.
- Lane 7 bits [15:0] = LEN, the number of 64-bit payload words that follow.
- Payload flits after the header = ceil(LEN/8), i.e. (LEN+7)>>3, computed in 17 bits. LEN=0 means a header-only packet.
- All lanes pass through unmodified, including partially filled last flits.

Reset (RST=0):
- Q=0, Q_VALID=0, Q_SRC=0, Q_HEAD=0.
- D_BP = all ones.
- State=IDLE, round-robin pointer RR=0, flit counter REM=0.
- Reset is asynchronous and effective mid-packet: the packet in flight is dropped and no partial continuation occurs after release.

Output register:
- OUT_RDY = ~Q_VALID | ~Q_BP.
- An accepted input flit appears on Q the next cycle (latency 1).
- While Q_VALID=1 and Q_BP=1, Q, Q_VALID, Q_SRC and Q_HEAD hold stable.

State machine:
- IDLE:
  - D_BP = all ones except the selected port.
  - Selected port = first i with D_VALID[i]=1, scanning RR, RR+1, ... modulo NUMPORTS.
  - If a port is selected and OUT_RDY: D_BP[sel]=0, the header is accepted, G is set to sel, and REM = (LEN+7)>>3.
  - Q_HEAD=1 is loaded with the header.
  - If REM would be 0: stay IDLE and set RR = sel+1 (mod NUMPORTS). Otherwise go to BUSY.
  - Selection is combinational in the same cycle, so back-to-back header-only packets from different ports sustain 1 flit/cycle.
- BUSY:
  - D_BP[G] = ~OUT_RDY; all other D_BP bits = 1.
  - Each accepted flit decrements REM and loads Q with Q_HEAD=0 and Q_SRC=G.
  - When the flit with REM=1 is accepted: set RR = G+1 (mod NUMPORTS) and go to IDLE.
  - D_VALID[G] may drop mid-packet (bubble). Grant is held and no other port is served.

Boundary conditions:
- All ports valid simultaneously: packets are served in strict rotation starting at RR.
- Only one port active: that port is re-granted immediately after its packet completes.
- Q_BP held high indefinitely: the granted port sees D_BP=1 and no flit is lost or duplicated.
- LEN=0xFFFF: REM=8192; the counter must not overflow.
- Q_BP toggling every cycle: throughput is 1 flit per 2 cycles with no loss and no reordering.

Test Plan:
- Single packet: port 0 sends a header with lane7=10, then 2 payload flits, Q_BP=0 -> Q shows 3 flits on consecutive cycles, 1 cycle after input; Q_HEAD=1 only on the first; Q_SRC=0; then IDLE and RR=1.
- Contention: ports 0..3 each present a LEN=8 packet simultaneously after reset -> output order is ports 0,1,2,3; each packet is 2 contiguous flits; no interleaving; D_BP is low only for the granted port.
- Header-only stream: ports 1 and 2 continuously present LEN=0 headers -> Q_SRC alternates 1,2,1,2 at 1 flit/cycle.
- Backpressure: mid-packet, Q_BP=1 for 5 cycles -> Q and Q_VALID hold, D_BP[G]=1; after release the remaining flits are delivered exactly once, in order.
- Input bubble: the granted port drops D_VALID for 3 cycles mid-packet while port 3 is valid -> port 3 is not granted until the granted packet finishes; Q_VALID=0 during the bubble.
- Reset mid-packet: RST=0 during the 2nd flit of a LEN=24 packet -> all outputs take reset values asynchronously; after release, the first Q flit is a fresh header with Q_HEAD=1.

Source files
------------

// File: rtl/routex_tx_arb.sv
// rtl/routex_tx_arb.sv - packet-granular round-robin merge of NUMPORTS 8x64 flit streams
module routex_tx_arb #(
    parameter int NUMPORTS = 4,
    parameter int PW       = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUMPORTS*512-1:0] D,
    input  logic [NUMPORTS-1:0]     D_VALID,
    output logic [NUMPORTS-1:0]     D_BP,
    output logic [511:0]            Q,
    output logic                    Q_VALID,
    output logic [PW-1:0]           Q_SRC,
    output logic                    Q_HEAD,
    input  logic                    Q_BP
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [PW-1:0]          rr;
    logic [PW-1:0]          g;
    logic [13:0]            rem;

    logic [511:0]           d_arr [NUMPORTS];
    logic [2*NUMPORTS-1:0]  dv_rot;
    logic [PW:0]            idx;
    logic [PW-1:0]          sel;
    logic                   sel_found;
    logic [PW-1:0]          cur;
    logic                   out_rdy;
    logic                   accept;
    logic [13:0]            hdr_rem;
    logic [NUMPORTS-1:0]    gnt_oh;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NUMPORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUMPORTS; i++) begin
            d_arr[i] = D[i*512 +: 512];
        end
    end

    // Rotate valids so bit 0 is the port at RR; the lowest set bit wins.
    assign dv_rot = {D_VALID, D_VALID} >> rr;

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int i = NUMPORTS - 1; i >= 0; i--) begin
            if (dv_rot[i]) begin
                sel_found = 1'b1;
                idx = {1'b0, rr} + (PW+1)'(i);
                if (idx >= (PW+1)'(NUMPORTS)) begin
                    idx = idx - (PW+1)'(NUMPORTS);
                end
                sel = idx[PW-1:0];
            end
        end
    end

    assign cur     = (state == BUSY) ? g : sel;
    assign out_rdy = ~Q_VALID | ~Q_BP;
    assign accept  = out_rdy & ((state == BUSY) ? D_VALID[g] : sel_found);

    // Payload flit count from LEN in lane 7; 17-bit sum keeps LEN=0xFFFF exact.
    assign hdr_rem = 14'(({1'b0, d_arr[sel][448 +: 16]} + 17'd7) >> 3);

    always_comb begin
        gnt_oh      = '0;
        gnt_oh[cur] = out_rdy & ((state == BUSY) | sel_found);
        D_BP        = RST ? ~gnt_oh : '1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            rr      <= '0;
            g       <= '0;
            rem     <= '0;
            Q       <= '0;
            Q_VALID <= 1'b0;
            Q_SRC   <= '0;
            Q_HEAD  <= 1'b0;
        end else begin
            if (accept) begin
                Q       <= d_arr[cur];
                Q_VALID <= 1'b1;
                Q_SRC   <= cur;
                Q_HEAD  <= (state == IDLE);
            end else if (out_rdy) begin
                Q_VALID <= 1'b0;
                Q_HEAD  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        g <= sel;
                        if (hdr_rem == '0) begin
                            rr <= nxt(sel);
                        end else begin
                            rem   <= hdr_rem;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (accept) begin
                        rem <= rem - 1'b1;
                        if (rem == 14'd1) begin
                            rr    <= nxt(g);
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_routex_tx_arb.sv
// tb/tb_routex_tx_arb.sv - randomized packet-level scoreboard bench for routex_tx_arb
module tb_routex_tx_arb;

    localparam int N  = 4;
    localparam int PW = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [N*512-1:0] D = '0;
    logic [N-1:0]     D_VALID = '0;
    logic [N-1:0]     D_BP;
    logic [511:0]     Q;
    logic             Q_VALID;
    logic [PW-1:0]    Q_SRC;
    logic             Q_HEAD;
    logic             Q_BP = 1'b0;

    routex_tx_arb #(.NUMPORTS(N), .PW(PW)) dut (
        .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_BP(D_BP),
        .Q(Q), .Q_VALID(Q_VALID), .Q_SRC(Q_SRC), .Q_HEAD(Q_HEAD), .Q_BP(Q_BP)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [511:0] data;
        int           src;
        logic         head;
    } flit_t;
    flit_t expq[$];

    // Per-port packet source
    logic [511:0] cur_f [N];
    bit           have [N];
    bit           cur_head [N];
    int           drv_rem [N];

    bit [N-1:0]   en;
    int           prob;
    int           len_max;
    int           len_fix;
    int           bp_mode;

    // Reference arbiter: packet-level round robin
    int           m_rr;
    int           m_g;
    int           m_rem;
    bit           m_busy;
    int           pkts_done;
    int           out_cnt;

    task automatic clear_model();
        expq.delete();
        for (int p = 0; p < N; p++) begin
            have[p] = 0;
            drv_rem[p] = 0;
        end
        m_rr = 0; m_g = 0; m_rem = 0; m_busy = 0;
    endtask

    task automatic step();
        int gp;
        int len;
        int r;
        bit ordy;
        logic [N-1:0] exp_bp;
        @(negedge CLK);
        case (bp_mode)
            0:       Q_BP = 1'b0;
            1:       Q_BP = ($urandom_range(2) == 0);
            2:       Q_BP = ~Q_BP;
            default: Q_BP = 1'b1;
        endcase
        for (int p = 0; p < N; p++) begin
            if (!have[p]) begin
                for (int w = 0; w < 16; w++) cur_f[p][w*32 +: 32] = $urandom();
                if (drv_rem[p] == 0) begin
                    len = (len_fix >= 0) ? len_fix : $urandom_range(len_max);
                    cur_f[p][448 +: 16] = 16'(len);
                    cur_head[p] = 1;
                end else begin
                    cur_head[p] = 0;
                end
                have[p] = 1;
            end
            D[p*512 +: 512] = cur_f[p];
            D_VALID[p] = (en[p] || drv_rem[p] != 0) && ($urandom_range(99) < prob);
        end
        #1;
        check("q_valid", Q_VALID, expq.size() != 0);
        if (expq.size() != 0) begin
            check("q_data", Q, expq[0].data);
            check("q_src", Q_SRC, expq[0].src);
            check("q_head", Q_HEAD, expq[0].head);
        end
        ordy = (expq.size() == 0) || !Q_BP;
        if (expq.size() != 0 && !Q_BP) begin
            void'(expq.pop_front());
            out_cnt++;
        end

        gp = -1;
        if (m_busy) begin
            gp = m_g;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gp < 0 && D_VALID[(m_rr + i) % N]) gp = (m_rr + i) % N;
            end
        end
        exp_bp = '1;
        if (gp >= 0 && ordy) exp_bp[gp] = 1'b0;
        check("d_bp", D_BP, exp_bp);

        if (gp >= 0 && ordy && D_VALID[gp]) begin
            expq.push_back('{data: cur_f[gp], src: gp, head: cur_head[gp]});
            have[gp] = 0;
            if (cur_head[gp]) begin
                len = int'(cur_f[gp][448 +: 16]);
                r = (len + 7) >> 3;
                drv_rem[gp] = r;
                m_g = gp;
                if (r == 0) begin
                    m_rr = (gp + 1) % N;
                    pkts_done++;
                end else begin
                    m_busy = 1;
                    m_rem = r;
                end
            end else begin
                drv_rem[gp]--;
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_rr = (m_g + 1) % N;
                    pkts_done++;
                end
            end
        end
    endtask

    task automatic drain();
        int budget;
        bit busy_any;
        en = '0; prob = 100; bp_mode = 0;
        budget = 20000;
        do begin
            step();
            budget--;
            busy_any = m_busy || expq.size() != 0;
            for (int p = 0; p < N; p++) if (drv_rem[p] != 0) busy_any = 1;
        end while (busy_any && budget > 0);
        if (busy_any) check("drain_timeout", 1, 0);
        for (int p = 0; p < N; p++) have[p] = 0;
    endtask

    task automatic phase(input bit [N-1:0] e, input int pr, input int lmax,
                         input int lfix, input int bpm, input int nsteps);
        en = e; prob = pr; len_max = lmax; len_fix = lfix; bp_mode = bpm;
        repeat (nsteps) step();
        drain();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        D_VALID = '0;
        Q_BP = 1'b0;
        #1;
        check("rst_q", Q, '0);
        check("rst_q_valid", Q_VALID, 0);
        check("rst_q_src", Q_SRC, 0);
        check("rst_q_head", Q_HEAD, 0);
        check("rst_d_bp", D_BP, {N{1'b1}});
        clear_model();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0;
        pkts_done = 0;
        out_cnt = 0;
        clear_model();
        en = '0; prob = 100; len_max = 0; len_fix = -1; bp_mode = 0;
        do_reset();

        // single packet, LEN=10 -> header + 2 payload flits
        phase(4'b0001, 100, 0, 10, 0, 3);

        // all four ports contend from RR=0
        do_reset();
        phase(4'b1111, 100, 0, 8, 0, 8);

        // header-only packets alternate between ports 1 and 2
        phase(4'b0110, 100, 0, 0, 0, 40);

        // random backpressure, random gaps
        phase(4'b1111, 70, 40, -1, 1, 1500);

        // backpressure held high
        phase(4'b1111, 100, 20, -1, 3, 10);

        // frequent input bubbles
        phase(4'b1111, 50, 30, -1, 0, 1500);

        // toggling backpressure: exactly one flit per two cycles
        en = 4'b0001; prob = 100; len_max = 30; len_fix = -1; bp_mode = 2;
        repeat (20) step();
        c0 = out_cnt;
        repeat (200) step();
        check("toggle_tput", out_cnt - c0, 100);
        drain();

        // LEN=0xFFFF -> 8192 payload flits
        c0 = out_cnt;
        pkts_done = 0;
        en = 4'b0001; prob = 100; len_fix = 65535; bp_mode = 0;
        for (int k = 0; k < 9000 && pkts_done == 0; k++) step();
        check("maxlen_done", pkts_done, 1);
        drain();
        check("maxlen_flits", out_cnt - c0, 8193);

        // reset in the middle of a LEN=24 packet
        do_reset();
        en = 4'b0001; prob = 100; len_fix = 24; bp_mode = 0;
        repeat (3) step();
        do_reset();
        phase(4'b0001, 100, 0, 24, 0, 6);

        // mixed random traffic
        phase(4'b1111, 80, 20, -1, 1, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
